serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/full_subtractor.sv | 15 +
 rtl/serial_subtractor.sv | 111 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: project data width and FSM state encoding.
package serial_subtractor_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: difference and borrow out from a, b and borrow in.
module full_subtractor (
    output logic D,
    output logic BO,
    input  logic A,
    input  logic B,
    input  logic BI
);

    always_comb begin
        D  = A ^ B ^ BI;
        BO = (~A & B) | (~(A ^ B) & BI);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, one bit per clock through a single reused full subtractor.
// Results are published only on the edge that processes the final bit.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             BO,
    output logic             V,
    output logic             Z,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [WIDTH-1:0] d_next;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             fs_d;
    logic             fs_bo;
    logic             last_bit;
    logic             capture;

    full_subtractor u_fs (
        .D  (fs_d),
        .BO (fs_bo),
        .A  (a_sr[0]),
        .B  (b_sr[0]),
        .BI (borrow)
    );

    always_comb begin
        last_bit = (cnt == CNT_W'(WIDTH - 1));
        capture  = START && (state != ST_BUSY);
        // New difference bit enters at the MSB; after WIDTH shifts it lands at bit 0.
        d_next   = (d_sr >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (START) state_next = ST_BUSY;
            ST_BUSY: if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = START ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            D      <= '0;
            BO     <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            BUSY <= (state_next == ST_BUSY);
            DONE <= (state_next == ST_DONE);
            if (capture) begin
                a_sr   <= A;
                b_sr   <= B;
                d_sr   <= '0;
                cnt    <= '0;
                borrow <= 1'b0;
            end else if (state == ST_BUSY) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                d_sr   <= d_next;
                borrow <= fs_bo;
                cnt    <= cnt + CNT_W'(1);
                if (last_bit) begin
                    // a_sr[0]/b_sr[0] hold the captured sign bits on the final step.
                    D  <= d_next;
                    BO <= fs_bo;
                    V  <= (a_sr[0] != b_sr[0]) && (fs_d != a_sr[0]);
                    Z  <= (d_next == '0);
                end
            end
        end
    end

endmodule
